// File: rtl/cf_fft_reorder_pp.sv
// rtl/cf_fft_reorder_pp.sv - ping-pong FFT reorder buffer, per-frame bit-reverse or natural order
module cf_fft_reorder_pp #(
    parameter int DW       = 16,
    parameter int LOG2N    = 10,
    parameter int MINLOG2N = 3
) (
    input  logic          clock_c,
    input  logic          reset_n,
    input  logic          en,
    input  logic [3:0]    cfg_log2n,
    input  logic          cfg_brev,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          out_sof,
    output logic          out_eof
);
    localparam int DEPTH = 2 ** LOG2N;
    localparam int EW    = 2 * DW + 2;

    typedef enum logic {IDLE, STREAM} state_t;
    state_t state_q, state_d;

    logic [2*DW-1:0]  mem [0:2*DEPTH-1];
    logic [2*DW-1:0]  ram_rdata;

    logic             wbank_q, wbank_d, rbank_q, rbank_d;
    logic [LOG2N-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [1:0]       full_q, full_d;
    logic [3:0]       tag_n_q [2];
    logic [3:0]       tag_n_d [2];
    logic [1:0]       tag_brev_q, tag_brev_d;
    logic             rd_vld_q, rd_vld_d, rd_sof_q, rd_sof_d, rd_eof_q, rd_eof_d;
    logic [EW-1:0]    fifo_q [2];
    logic [EW-1:0]    fifo_d [2];
    logic             fwp_q, fwp_d, frp_q, frp_d;
    logic [1:0]       fcnt_q, fcnt_d;

    logic [3:0]       cfg_n, wn, rn;
    logic             wbrev, wr_fire, wr_last, rd_issue, rd_last, pop, room;
    logic [LOG2N-1:0] wrev, waddr, wlim, rlim;

    always_comb begin
        cfg_n = cfg_log2n;
        if (cfg_log2n < 4'(MINLOG2N)) begin
            cfg_n = 4'(MINLOG2N);
        end else if (cfg_log2n > 4'(LOG2N)) begin
            cfg_n = 4'(LOG2N);
        end
    end

    // the first sample of a frame uses live cfg; the rest use the tag latched with it
    always_comb begin
        wn    = (wcnt_q == '0) ? cfg_n : tag_n_q[wbank_q];
        wbrev = (wcnt_q == '0) ? cfg_brev : tag_brev_q[wbank_q];
        for (int k = 0; k < LOG2N; k++) begin
            wrev[k] = wcnt_q[LOG2N-1-k];
        end
        waddr     = wbrev ? (wrev >> (4'(LOG2N) - wn)) : wcnt_q;
        wlim      = LOG2N'((32'd1 << wn) - 32'd1);
        rn        = tag_n_q[rbank_q];
        rlim      = LOG2N'((32'd1 << rn) - 32'd1);
        in_ready  = reset_n & ~full_q[wbank_q];
        wr_fire   = in_valid & in_ready & en;
        wr_last   = (wcnt_q == wlim);
        out_valid = (fcnt_q != 2'd0);
        pop       = out_valid & out_ready & en;
        // a read issued now lands in the skid FIFO two edges later; keep one slot for it
        room      = (3'(fcnt_q) + 3'(rd_vld_q) - 3'(pop)) <= 3'd1;
        rd_last   = (rcnt_q == rlim);
    end

    always_ff @(posedge clock_c) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rd_issue && !rd_last) state_d = STREAM;
            STREAM:  if (rd_issue && rd_last) state_d = full_q[~rbank_q] ? STREAM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_issue = en && room && (state_q == STREAM || full_q[rbank_q]);
    end

    always_comb begin
        wbank_d    = wbank_q;
        wcnt_d     = wcnt_q;
        rbank_d    = rbank_q;
        rcnt_d     = rcnt_q;
        full_d     = full_q;
        tag_n_d    = tag_n_q;
        tag_brev_d = tag_brev_q;
        rd_vld_d   = rd_issue;
        rd_sof_d   = rd_issue && (rcnt_q == '0);
        rd_eof_d   = rd_issue && rd_last;
        fifo_d     = fifo_q;
        fwp_d      = fwp_q;
        frp_d      = frp_q;
        fcnt_d     = fcnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
        if (wr_fire) begin
            if (wcnt_q == '0) begin
                tag_n_d[wbank_q]    = cfg_n;
                tag_brev_d[wbank_q] = cfg_brev;
            end
            if (wr_last) begin
                full_d[wbank_q] = 1'b1;
                wcnt_d          = '0;
                wbank_d         = ~wbank_q;
            end else begin
                wcnt_d = wcnt_q + LOG2N'(1);
            end
        end
        if (rd_issue) begin
            if (rd_last) begin
                full_d[rbank_q] = 1'b0;
                rcnt_d          = '0;
                rbank_d         = ~rbank_q;
            end else begin
                rcnt_d = rcnt_q + LOG2N'(1);
            end
        end
        if (rd_vld_q) begin
            fifo_d[fwp_q] = {rd_sof_q, rd_eof_q, ram_rdata};
            fwp_d         = ~fwp_q;
        end
        if (pop) begin
            frp_d = ~frp_q;
        end
    end

    always_ff @(posedge clock_c) begin
        if (!reset_n) begin
            wbank_q    <= 1'b0;
            wcnt_q     <= '0;
            rbank_q    <= 1'b0;
            rcnt_q     <= '0;
            full_q     <= 2'b00;
            tag_n_q[0] <= 4'(MINLOG2N);
            tag_n_q[1] <= 4'(MINLOG2N);
            tag_brev_q <= 2'b00;
            rd_vld_q   <= 1'b0;
            rd_sof_q   <= 1'b0;
            rd_eof_q   <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            fwp_q      <= 1'b0;
            frp_q      <= 1'b0;
            fcnt_q     <= 2'd0;
        end else if (en) begin
            wbank_q    <= wbank_d;
            wcnt_q     <= wcnt_d;
            rbank_q    <= rbank_d;
            rcnt_q     <= rcnt_d;
            full_q     <= full_d;
            tag_n_q    <= tag_n_d;
            tag_brev_q <= tag_brev_d;
            rd_vld_q   <= rd_vld_d;
            rd_sof_q   <= rd_sof_d;
            rd_eof_q   <= rd_eof_d;
            fifo_q     <= fifo_d;
            fwp_q      <= fwp_d;
            frp_q      <= frp_d;
            fcnt_q     <= fcnt_d;
        end
    end

    always_ff @(posedge clock_c) begin
        if (wr_fire) begin
            mem[{wbank_q, waddr}] <= {in_re, in_im};
        end
        if (rd_issue) begin
            ram_rdata <= mem[{rbank_q, rcnt_q}];
        end
    end

    assign {out_sof, out_eof, out_re, out_im} = fifo_q[frp_q];

endmodule
